// File: rtl/serializer.sv
// LSB-first parallel-to-serial frame transmitter with IDLE/SHIFT/DONE control.
// Define SERIALIZER_CRC7_EN to append a CRC7 (x^7+x^3+1) trailer in a CRC state.
module serializer #(
    parameter int BITS         = 136,
    parameter int BITS_COUNTER = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    start,
    input  logic [BITS_COUNTER-1:0] framesize,
    input  logic [BITS-1:0]         in,
    output logic                    out,
    output logic                    out_en,
    output logic                    busy,
    output logic                    complete
);

`ifdef SERIALIZER_CRC7_EN
    typedef enum logic [1:0] {IDLE, SHIFT, CRC, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t                  state_q;
    logic [BITS_COUNTER-1:0] cnt_q;
    logic [BITS_COUNTER-1:0] size_q;
    logic [BITS_COUNTER-1:0] size_d;
    logic [BITS-1:0]         sh_q;
    logic                    out_q;
    logic                    out_en_q;
    logic                    busy_q;
    logic                    complete_q;
    logic                    last_bit;
`ifdef SERIALIZER_CRC7_EN
    logic [6:0]              crc_q;

    function automatic logic [6:0] crc_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction
`endif

    function automatic logic [BITS_COUNTER-1:0] clamp_size(input logic [BITS_COUNTER-1:0] fs);
        if (int'(fs) > BITS)
            return BITS_COUNTER'(BITS);
        return fs;
    endfunction

    assign size_d   = clamp_size(framesize);
    assign last_bit = ((cnt_q + BITS_COUNTER'(1)) == size_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            out_q      <= 1'b1;
            out_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
`ifdef SERIALIZER_CRC7_EN
            crc_q      <= '0;
`endif
        end else if (enable) begin
            case (state_q)
                IDLE: begin
                    complete_q <= 1'b0;
                    if (start) begin
                        size_q <= size_d;
                        sh_q   <= in >> 1;
                        cnt_q  <= '0;
`ifdef SERIALIZER_CRC7_EN
                        crc_q  <= (size_d != '0) ? crc_step(7'h00, in[0]) : 7'h00;
`endif
                        if (size_d == '0) begin
                            state_q    <= DONE;
                            complete_q <= 1'b1;
                            out_q      <= 1'b1;
                            out_en_q   <= 1'b0;
                            busy_q     <= 1'b0;
                        end else begin
                            state_q  <= SHIFT;
                            out_q    <= in[0];
                            out_en_q <= 1'b1;
                            busy_q   <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (last_bit) begin
`ifdef SERIALIZER_CRC7_EN
                        // crc_q already covers every payload bit; stream it MSB first
                        state_q <= CRC;
                        cnt_q   <= '0;
                        out_q   <= crc_q[6];
                        crc_q   <= {crc_q[5:0], 1'b0};
`else
                        state_q    <= DONE;
                        out_q      <= 1'b1;
                        out_en_q   <= 1'b0;
                        busy_q     <= 1'b0;
                        complete_q <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q + BITS_COUNTER'(1);
                        out_q <= sh_q[0];
                        sh_q  <= sh_q >> 1;
`ifdef SERIALIZER_CRC7_EN
                        crc_q <= crc_step(crc_q, sh_q[0]);
`endif
                    end
                end
`ifdef SERIALIZER_CRC7_EN
                CRC: begin
                    if (cnt_q == BITS_COUNTER'(6)) begin
                        state_q    <= DONE;
                        out_q      <= 1'b1;
                        out_en_q   <= 1'b0;
                        busy_q     <= 1'b0;
                        complete_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + BITS_COUNTER'(1);
                        out_q <= crc_q[6];
                        crc_q <= {crc_q[5:0], 1'b0};
                    end
                end
`endif
                DONE: begin
                    state_q    <= IDLE;
                    complete_q <= 1'b0;
                    out_q      <= 1'b1;
                    out_en_q   <= 1'b0;
                    busy_q     <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    out_q      <= 1'b1;
                    out_en_q   <= 1'b0;
                    busy_q     <= 1'b0;
                    complete_q <= 1'b0;
                end
            endcase
        end
    end

    assign out      = out_q;
    assign out_en   = out_en_q;
    assign busy     = busy_q;
    assign complete = complete_q;

endmodule

// File: doc/serializer.md
SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 Parameters SHALL be: BITS, default 136, maximum frame width; BITS_COUNTER, default 8, counter width, at least log2(BITS)+1.
REQ-002 clk  input  1  bit clock; all state changes on posedge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 enable  input  1  high = advance one bit per clock; low = freeze all state and outputs.
REQ-005 start  input  1  request to transmit; sampled only in IDLE while enable=1.
REQ-006 framesize  input  BITS_COUNTER  number of payload bits; sampled with start.
REQ-007 in  input  BITS  parallel payload; sampled with start.
REQ-008 out  output  1  serial data; 1 when not driving a frame.
REQ-009 out_en  output  1  high while out carries a frame bit.
REQ-010 busy  output  1  high in SHIFT and CRC states.
REQ-011 complete  output  1  one-cycle pulse after the last bit of a frame.

Function
REQ-012 States SHALL be IDLE, SHIFT, CRC and DONE; all outputs SHALL be registered.
REQ-013 IDLE with enable=1 and start=1 at edge T SHALL capture in and framesize, clear the bit counter, and enter SHIFT; in[0] SHALL appear on out with out_en=1 from T+1.
REQ-014 Bits SHALL be sent LSB-first, in[0] up to in[framesize-1], one bit per enabled clock, matching index order in the team's deserializer.
REQ-015 After bit framesize-1 has been held for one enabled clock, the block SHALL enter CRC (macro defined) or DONE (macro undefined).
REQ-016 DONE SHALL hold complete=1, out=1, out_en=0, busy=0 for exactly one enabled clock, then return to IDLE.
REQ-017 A framesize of 0 SHALL go IDLE->DONE directly: no bits sent, and complete SHALL pulse at T+1.
REQ-018 A framesize greater than BITS SHALL be clamped to BITS.
REQ-019 start SHALL be ignored outside IDLE; in and framesize changes after capture SHALL have no effect.
REQ-020 With enable=0 the state, counter, shift data and all outputs SHALL hold; complete, if high, SHALL stay high until the next enabled clock.
REQ-021 The counter SHALL never wrap; framesize=BITS SHALL send exactly BITS bits.
REQ-022 out_en SHALL be high for exactly framesize (plus 7 with the macro) enabled clocks per frame.

Reset
REQ-023 When reset=0 at a posedge, the block SHALL enter IDLE regardless of enable: out=1, out_en=0, busy=0, complete=0, counter=0, CRC register=0.
REQ-024 Reset mid-frame SHALL abort the frame with no complete pulse; a start with reset=0 SHALL be ignored.

Configuration
REQ-025 Macro SERIALIZER_CRC7_EN: when defined, the block SHALL compute CRC7 over the transmitted payload bits and send it in state CRC.
REQ-026 CRC7 details: polynomial x^7+x^3+1, register cleared at start, feedback = payload bit XOR crc[6]; CRC SHALL be sent crc[6] first over 7 enabled clocks with out_en=1, then DONE follows.
REQ-027 When SERIALIZER_CRC7_EN is undefined, there SHALL be no CRC state or logic, and SHIFT SHALL go directly to DONE.

Verification
REQ-028 Reset: hold reset=0 for 3 clocks with start=1 -> out=1, out_en=0, busy=0, complete=0 throughout.
REQ-029 Basic frame: framesize=8, in=0xA5, enable=1 -> out sequence 1,0,1,0,0,1,0,1 on 8 clocks after T; complete pulse on clock 9 (macro undefined).
REQ-030 Stall: same frame with enable=0 for 4 clocks after bit 3 -> bit 3 held 5 cycles; total sequence unchanged; complete is delayed by 4 cycles.
REQ-031 Edge sizes: framesize=0 -> complete at T+1 with no out_en; framesize=200 with BITS=136 -> exactly 136 bits sent.
REQ-032 Abort: reset=0 after bit 5 of a 48-bit frame -> IDLE next edge, no complete pulse; start 2 clocks later is accepted normally.
REQ-033 CRC (macro defined): framesize=40, payload 0x4000000000 sent LSB-first -> 40 payload bits, then 7 CRC bits matching a reference model, then complete; loopback into the deserializer with framesize=47 recovers payload+CRC.
